// File: rtl/lfsr_checker.sv
// LFSR sequence checker: hunts for a seed, syncs on consecutive matching samples,
// then tracks the free-running sequence. Optional error counter under LFSR_CHK_ERRCNT_EN.
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        err_clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [7:0]  expected
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_C = 4'(LOSS_CNT);

    // All-zero is a stuck state for this LFSR, so it is mapped onto the seed 01.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        logic [7:0] y;
        if (x == 8'h00) begin
            y = 8'h01;
        end else begin
            y = {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
        end
        return y;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] expected_r, expected_s;
    logic [3:0] match_r, match_s;
    logic [3:0] miss_r, miss_s;
    logic       locked_r;
    logic       err_pulse_r;
    logic       err_s;

    // Next-state, prediction and counter logic for one sample.
    always_comb begin
        state_s    = state_r;
        expected_s = expected_r;
        match_s    = match_r;
        miss_s     = miss_r;
        err_s      = 1'b0;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    expected_s = lfsr_next(in_data);
                    match_s    = 4'd0;
                    state_s    = SYNC;
                end
                SYNC: begin
                    expected_s = lfsr_next(in_data);
                    if (in_data == expected_r) begin
                        match_s = match_r + 4'd1;
                        if (match_s == LOCK_CNT_C) begin
                            state_s = LOCK;
                            miss_s  = 4'd0;
                        end else begin
                            state_s = SYNC;
                        end
                    end else begin
                        match_s = 4'd0;
                        state_s = SYNC;
                    end
                end
                LOCK: begin
                    // Once locked the prediction free-runs; the sample only scores it.
                    expected_s = lfsr_next(expected_r);
                    if (in_data != expected_r) begin
                        err_s  = 1'b1;
                        miss_s = miss_r + 4'd1;
                        if (miss_s == LOSS_CNT_C) begin
                            state_s = HUNT;
                            miss_s  = 4'd0;
                        end else begin
                            state_s = LOCK;
                        end
                    end else begin
                        miss_s = 4'd0;
                    end
                end
                default: begin
                    state_s    = HUNT;
                    expected_s = 8'h01;
                    match_s    = 4'd0;
                    miss_s     = 4'd0;
                end
            endcase
        end else begin
            state_s    = state_r;
            expected_s = expected_r;
        end
    end

    // State, prediction, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= HUNT;
            expected_r  <= 8'h01;
            match_r     <= 4'd0;
            miss_r      <= 4'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            match_r     <= match_s;
            miss_r      <= miss_s;
            locked_r    <= (state_s == LOCK);
            err_pulse_r <= err_s;
        end
    end

`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0] err_count_r;

    // Saturating error counter; a clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= 16'h0000;
        end else if (err_clr) begin
            err_count_r <= 16'h0000;
        end else if (err_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_count        = 16'h0000;
`endif

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign expected  = expected_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: reference model feeds a scoreboard queue,
// directed steps cover lock, zero seed, errors, loss, clear collision, gaps and reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;

    int total = 0;
    int bad   = 0;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .expected(expected)
    );

    always #5 clk = ~clk;

    // Reference model state: 0 hunt, 1 sync, 2 lock.
    int          m_state;
    logic [7:0]  m_exp;
    int          m_match;
    int          m_miss;
    logic [15:0] m_cnt;
    logic        m_pulse;
    logic [25:0] sb_q[$];

    function automatic logic [7:0] succ(input logic [7:0] x);
        logic [7:0] fb;
        fb = x & 8'h1D;
        if (x == 8'h00) return 8'h01;
        return {^fb, x[7:1]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 8'h01; m_match = 0; m_miss = 0;
        m_cnt = 16'h0000; m_pulse = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic c);
        logic inc;
        inc = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                m_exp = succ(d); m_match = 0; m_state = 1;
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_match++;
                    if (m_match == 4) begin m_state = 2; m_miss = 0; end
                end else begin
                    m_match = 0;
                end
                m_exp = succ(d);
            end else begin
                if (d != m_exp) begin
                    inc = 1'b1; m_miss++;
                    if (m_miss == 3) begin m_state = 0; m_miss = 0; end
                end else begin
                    m_miss = 0;
                end
                m_exp = succ(m_exp);
            end
        end
        m_pulse = inc;
`ifdef LFSR_CHK_ERRCNT_EN
        if (c) m_cnt = 16'h0000;
        else if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
`else
        m_cnt = 16'h0000;
`endif
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Drive one cycle, push model prediction, then pop and compare after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        logic [25:0] e;
        @(negedge clk);
        in_valid = v; in_data = d; err_clr = c;
        model_update(v, d, c);
        sb_q.push_back({(m_state == 2), m_pulse, m_cnt, m_exp});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check("locked",    {15'd0, locked},    {15'd0, e[25]});
        check("err_pulse", {15'd0, err_pulse}, {15'd0, e[24]});
        check("err_count", err_count,          e[23:8]);
        check("expected",  {8'd0, expected},   {8'd0, e[7:0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; err_clr = 1'b0; rst = 1'b1;
        #1;
        check("rst_locked",    {15'd0, locked},    16'h0000);
        check("rst_err_pulse", {15'd0, err_pulse}, 16'h0000);
        check("rst_err_count", err_count,          16'h0000);
        check("rst_expected",  {8'd0, expected},   16'h0001);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq0 [5];
        seq0 = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10};
        model_reset();
        #2;
        do_reset();

        // Lock on 01,80,40,20,10 then 88.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq0[i], 1'b0);
            if (i == 3) check("not_yet_locked", {15'd0, locked}, 16'h0000);
        end
        check("lock_after_10", {15'd0, locked}, 16'h0001);
        check("exp_after_10", {8'd0, expected}, 16'h0088);
        step(1'b1, 8'h88, 1'b0);

        // Single error then correct stream.
        step(1'b1, m_exp ^ 8'h01, 1'b0);
        check("single_pulse", {15'd0, err_pulse}, 16'h0001);
        check("single_locked", {15'd0, locked}, 16'h0001);
        step(1'b1, m_exp, 1'b0);
        check("pulse_one_cycle", {15'd0, err_pulse}, 16'h0000);
        step(1'b1, m_exp, 1'b0);

        // Loss after three consecutive misses, then relock on five correct samples.
        for (int i = 0; i < 3; i++) step(1'b1, m_exp ^ 8'h5A, 1'b0);
        check("loss_unlocked", {15'd0, locked}, 16'h0000);
        check("loss_pulse", {15'd0, err_pulse}, 16'h0001);
        for (int i = 0; i < 5; i++) step(1'b1, seq0[i], 1'b0);
        check("relocked", {15'd0, locked}, 16'h0001);

        // Zero seed: 00 then 01 is a match, so lock comes after 20.
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        check("zero_lock", {15'd0, locked}, 16'h0001);

        // Five isolated errors, then err_clr colliding with a sixth.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, m_exp ^ 8'h80, 1'b0);
            step(1'b1, m_exp, 1'b0);
        end
`ifdef LFSR_CHK_ERRCNT_EN
        check("count_5", err_count, 16'h0005);
`else
        check("count_tied", err_count, 16'h0000);
`endif
        step(1'b1, m_exp ^ 8'h80, 1'b1);
        check("clr_count", err_count, 16'h0000);
        check("clr_pulse", {15'd0, err_pulse}, 16'h0001);
        check("clr_locked", {15'd0, locked}, 16'h0001);
        step(1'b0, 8'hFF, 1'b0);

        // Gapped input gives the same lock timing in valid samples.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq0[i], 1'b0);
            if (i < 4) begin
                check("gap_unlocked", {15'd0, locked}, 16'h0000);
                step(1'b0, 8'hA5, 1'b0);
            end
        end
        check("gap_lock", {15'd0, locked}, 16'h0001);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, m_exp, 1'b0);

        // Reset while locked, then the next sample is a fresh seed.
        do_reset();
        step(1'b1, 8'h40, 1'b0);
        check("post_rst_seed", {8'd0, expected}, 16'h0020);
        step(1'b1, 8'h20, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, 4: consecutive correct predictions needed to declare lock (range 1..15).
REQ-002 SHALL have parameter LOSS_CNT, 3: consecutive mispredictions while locked that drop lock (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data carries a sample this cycle.
REQ-006 SHALL have port in_data  input  8  received LFSR sample.
REQ-007 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-008 SHALL have port locked  output  1  checker is tracking the sequence.
REQ-009 SHALL have port err_pulse  output  1  one-cycle flag for a mispredicted sample while locked.
REQ-010 SHALL have port err_count  output  16  saturating count of mispredictions while locked.
REQ-011 SHALL have port expected  output  8  predicted value of the next sample.

Function
REQ-012 SHALL use successor function N(x) = {x[4]^x[3]^x[2]^x[0], x[7:1]} for x != 8'h00, and N(8'h00) = 8'h01.
REQ-013 SHALL implement states HUNT, SYNC and LOCK, with all outputs registered.
REQ-014 SHALL in HUNT, on in_valid: load expected <= N(in_data), clear match counter, and go to SYNC.
REQ-015 SHALL in SYNC, on in_valid with in_data == expected: set expected <= N(in_data) and increment the match counter.
REQ-016 SHALL go from SYNC to LOCK on the sample that makes the match counter equal LOCK_CNT.
REQ-017 SHALL in SYNC, on in_valid with a mismatch: reseed expected <= N(in_data), clear the match counter, and stay in SYNC.
REQ-018 SHALL in LOCK, on every in_valid, advance expected <= N(expected), free-running and independent of in_data.
REQ-019 SHALL in LOCK, on a mismatch: assert err_pulse in the next cycle for one cycle, increment err_count, and increment the miss counter.
REQ-020 SHALL in LOCK, on a match: clear the miss counter.
REQ-021 SHALL go from LOCK to HUNT on the mismatch that makes the miss counter equal LOSS_CNT; that mismatch is still counted and pulsed.
REQ-022 SHALL hold all state, counters and expected in cycles with in_valid = 0.
REQ-023 SHALL make locked a registered decode of the LOCK state: it rises the cycle after the locking sample and falls the cycle after the losing sample.
REQ-024 SHALL saturate err_count at 16'hFFFF with no wrap.
REQ-025 SHALL, when err_clr is asserted, set err_count to 0 next cycle; err_clr takes priority over a simultaneous error increment (result 0).
REQ-026 SHALL NOT let err_clr affect state, err_pulse, locked or expected.
REQ-027 SHALL never increment err_count or assert err_pulse outside LOCK.

Reset
REQ-028 SHALL, while rst is high, asynchronously force: state = HUNT, locked = 0, err_pulse = 0, err_count = 0, expected = 8'h01, match counter = 0, miss counter = 0.
REQ-029 SHALL take reset asserted mid-stream with immediate effect; after release, the next valid sample is treated as a HUNT seed.

Configuration
REQ-030 SHALL, with macro LFSR_CHK_ERRCNT_EN defined, implement err_count and err_clr as specified above.
REQ-031 SHALL, without LFSR_CHK_ERRCNT_EN, tie err_count to 16'h0000 and ignore err_clr; err_pulse, lock and state behaviour are unchanged.

Verification
REQ-032 SHALL pass Lock: valid every cycle with 01,80,40,20,10,88 -> locked = 1 the cycle after 10 (sample 5), err_count = 0, expected = 88 after 10.
REQ-033 SHALL pass Zero handling: in HUNT feed 00 then 01 -> 01 is counted as a match (expected was 01), with no reseed.
REQ-034 SHALL pass Single error: locked, send 21 where 20 expected, then the correct stream -> one err_pulse, err_count = 1, locked stays 1, the next sample 10 matches.
REQ-035 SHALL pass Loss: locked, 3 consecutive wrong samples -> 3 err_pulses, err_count = 3, locked = 0 the cycle after the third, then relocks after 5 correct samples.
REQ-036 SHALL pass Clear collision: err_clr coincident with a mismatch while err_count = 5 -> err_count = 0 and err_pulse still = 1; without LFSR_CHK_ERRCNT_EN, err_count remains 0 throughout.
REQ-037 SHALL pass Reset mid-lock plus gaps: in_valid toggled 1/0 gives the same lock timing counted in valid samples; rst pulsed while locked -> all outputs at reset values within the same cycle, expected = 01.
